// File: rtl/enemy_formation_if.sv
// enemy_formation_if: frame request, alive mask and sprite-plotter handshake for enemy_formation_ctrl.
// Carries plotted_cnt only when ENEMY_FORMATION_PLOT_CNT_EN is defined.
interface enemy_formation_if #(parameter int N = 24);
    logic         frame_tick;
    logic [N-1:0] alive;
    logic         enemy_done;
    logic         enemy_enable;
    logic [8:0]   x_pos;
    logic [7:0]   y_pos;
    logic         busy;
    logic         pass_done;
    logic         reached_bottom;
`ifdef ENEMY_FORMATION_PLOT_CNT_EN
    logic [5:0]   plotted_cnt;
    modport master (output frame_tick, alive, enemy_done,
                    input enemy_enable, x_pos, y_pos, busy, pass_done, reached_bottom, plotted_cnt);
    modport slave (input frame_tick, alive, enemy_done,
                   output enemy_enable, x_pos, y_pos, busy, pass_done, reached_bottom, plotted_cnt);
`else
    modport master (output frame_tick, alive, enemy_done,
                    input enemy_enable, x_pos, y_pos, busy, pass_done, reached_bottom);
    modport slave (input frame_tick, alive, enemy_done,
                   output enemy_enable, x_pos, y_pos, busy, pass_done, reached_bottom);
`endif
endinterface

// File: rtl/enemy_formation_ctrl.sv
// enemy_formation_ctrl: walks the enemy grid once per frame_tick, requesting a plot per live enemy,
// and steps the formation every MOVE_DIV passes. ENEMY_FORMATION_PLOT_CNT_EN adds plotted_cnt.
module enemy_formation_ctrl #(
    parameter int COLS      = 8,
    parameter int ROWS      = 3,
    parameter int X_SPACING = 32,
    parameter int Y_SPACING = 24,
    parameter int STEP_X    = 4,
    parameter int STEP_Y    = 8,
    parameter int MOVE_DIV  = 4,
    parameter int X_START   = 16,
    parameter int Y_START   = 16,
    parameter int Y_LIMIT   = 200
) (
    input logic              clk,
    input logic              reset,
    enemy_formation_if.slave bus
);
    localparam int N      = ROWS * COLS;
    localparam int FORM_W = (COLS - 1) * X_SPACING + 28;
    localparam int FORM_H = (ROWS - 1) * Y_SPACING + 20;
    localparam int IW     = N > 1 ? $clog2(N) : 1;
    localparam int CW     = COLS > 1 ? $clog2(COLS) : 1;
    localparam int RW     = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int PW     = MOVE_DIV > 1 ? $clog2(MOVE_DIV) : 1;
    // Edge tests rearranged so they compare the origin against constants only
    localparam logic [8:0] SX        = 9'(STEP_X);
    localparam logic [8:0] RIGHT_MAX = 9'(320 - FORM_W - STEP_X);
    localparam logic [7:0] SY        = 8'(STEP_Y);
    localparam logic [8:0] BOTTOM    = 9'(Y_LIMIT - FORM_H);

    typedef enum logic [2:0] {IDLE, SELECT, PLOT, NEXT, MOVE} state_t;

    state_t        state, nxt;
    logic [IW-1:0] idx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] pass_cnt;
    logic [8:0]    ox, x_q;
    logic [7:0]    oy, y_q, ny;
    logic          dir_left, reached, en_q;
    logic          last, col_last, step, edge_hit;

    assign last     = idx == IW'(N - 1);
    assign col_last = col == CW'(COLS - 1);
    assign step     = pass_cnt == PW'(MOVE_DIV - 1) && !reached;
    assign edge_hit = dir_left ? ox < SX : ox > RIGHT_MAX;
    assign ny       = oy + SY;

    assign bus.enemy_enable   = en_q;
    assign bus.x_pos          = x_q;
    assign bus.y_pos          = y_q;
    assign bus.reached_bottom = reached;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.frame_tick ? SELECT : IDLE;
            SELECT:  nxt = bus.alive[idx] ? PLOT : NEXT;
            PLOT:    nxt = bus.enemy_done ? NEXT : PLOT;
            NEXT:    nxt = last ? MOVE : SELECT;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = state != IDLE;
        bus.pass_done = state == MOVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            idx      <= '0;
            col      <= '0;
            row      <= '0;
            pass_cnt <= '0;
            ox       <= 9'(X_START);
            oy       <= 8'(Y_START);
            dir_left <= 1'b0;
            reached  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.frame_tick) begin
                    idx <= '0;
                    col <= '0;
                    row <= '0;
                end
                SELECT: begin
                    x_q  <= ox + 9'(col) * 9'(X_SPACING);
                    y_q  <= oy + 8'(row) * 8'(Y_SPACING);
                    en_q <= bus.alive[idx];
                end
                PLOT: en_q <= en_q && !bus.enemy_done;
                NEXT: if (!last) begin
                    idx <= idx + 1'b1;
                    col <= col_last ? '0 : col + 1'b1;
                    row <= col_last ? row + 1'b1 : row;
                end
                MOVE: begin
                    pass_cnt <= pass_cnt == PW'(MOVE_DIV - 1) ? '0 : pass_cnt + 1'b1;
                    if (step && edge_hit) begin
                        oy       <= ny;
                        dir_left <= !dir_left;
                        reached  <= {1'b0, ny} >= BOTTOM;
                    end else if (step) begin
                        ox <= dir_left ? ox - SX : ox + SX;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ENEMY_FORMATION_PLOT_CNT_EN
    logic [5:0] plot_acc, plot_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plot_acc   <= '0;
            plot_cnt_q <= '0;
        end else if (state == SELECT && bus.alive[idx] && plot_acc != 6'd63) begin
            plot_acc <= plot_acc + 1'b1;
        end else if (state == MOVE) begin
            plot_cnt_q <= plot_acc;
            plot_acc   <= '0;
        end
    end

    assign bus.plotted_cnt = plot_cnt_q;
`endif
endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// tb_enemy_formation_ctrl: directed checks of enemy_formation_ctrl with a delayed-done plotter model.
module tb_enemy_formation_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   dly = 562;
    int   pcnt = 0;
    int   n_done = 0;
    int   rises[$];
    logic en_prev = 1'b0;
    int   np = 0;

    enemy_formation_if #(.N(24)) bus();

    enemy_formation_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Plotter: done while idle, otherwise dly cycles after enable rises
    always @(posedge clk) pcnt <= bus.enemy_enable ? pcnt + 1 : 0;
    assign bus.enemy_done = !bus.enemy_enable || (pcnt == dly - 1);

    always @(negedge clk) begin
        if (bus.enemy_enable && !en_prev) rises.push_back(int'(bus.x_pos) * 256 + int'(bus.y_pos));
        en_prev = bus.enemy_enable;
        if (bus.pass_done) n_done++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic start_tick(input logic [23:0] a);
        bus.alive = a;
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1 bus.frame_tick = 1'b0;
    endtask

    task automatic run_pass(input logic [23:0] a, output int cyc);
        start_tick(a);
        cyc = 0;
        while (!bus.pass_done && cyc < 20000) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("pass_done", int'(bus.pass_done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic passes(input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            run_pass('0, c);
            np++;
        end
    endtask

    // An empty pass leaves x/y at the last slot: origin + (224, 48)
    task automatic observe(input string tag, input int ex, input int ey);
        int c;
        run_pass('0, c);
        np++;
        check({tag, "_x"}, int'(bus.x_pos), ex);
        check({tag, "_y"}, int'(bus.y_pos), ey);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        np = 0;
    endtask

    initial begin
        int c, b_en, b_d;
        bus.frame_tick = 1'b0;
        bus.alive = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_enable", int'(bus.enemy_enable), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_pass_done", int'(bus.pass_done), 0);
        check("rst_x", int'(bus.x_pos), 0);
        check("rst_y", int'(bus.y_pos), 0);
        check("rst_bottom", int'(bus.reached_bottom), 0);
        @(negedge clk);
        reset = 1'b0;
        b_en = rises.size();
        b_d = n_done;
        run_pass(24'hFFFFFF, c);
        check("full_enables", rises.size() - b_en, 24);
        check("full_first_x", rises[b_en] / 256, 16);
        check("full_first_y", rises[b_en] % 256, 16);
        check("full_last_x", rises[$] / 256, 240);
        check("full_last_y", rises[$] % 256, 64);
        check("full_passes", n_done - b_d, 1);
        check("full_busy_after", int'(bus.busy), 0);
        b_en = rises.size();
        b_d = n_done;
        run_pass(24'h000001, c);
        check("one_enables", rises.size() - b_en, 1);
        check("one_x", rises[b_en] / 256, 16);
        check("one_y", rises[b_en] % 256, 16);
        check("one_cycles", c, 610);
        check("one_passes", n_done - b_d, 1);
        do_reset();
        run_pass('0, c);
        np++;
        check("empty_cycles", c, 48);
        passes(39);
        observe("p41", 280, 64);
        passes(11);
        observe("p53", 292, 64);
        passes(3);
        observe("p57", 292, 72);
        passes(3);
        observe("p61", 288, 72);
        while (!bus.reached_bottom && np < 1100) passes(1);
        check("bottom_pass", np, 1064);
        check("bottom_flag", int'(bus.reached_bottom), 1);
        observe("frozen", 292, 184);
        passes(8);
        observe("frozen_late", 292, 184);
        check("bottom_sticky", int'(bus.reached_bottom), 1);
        dly = 40;
        do_reset();
        check("rst2_bottom", int'(bus.reached_bottom), 0);
        b_en = rises.size();
        b_d = n_done;
        start_tick(24'h000001);
        c = 0;
        while (!bus.enemy_enable && c < 10) begin
            @(posedge clk);
            #1 c++;
        end
        check("plot_start", int'(bus.enemy_enable), 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        c = 0;
        while (!bus.pass_done && c < 2000) begin
            @(posedge clk);
            #1 c++;
        end
        check("tick_pass_done", int'(bus.pass_done), 1);
        repeat (150) @(posedge clk);
        #1;
        check("tick_ignored_passes", n_done - b_d, 1);
        check("tick_ignored_enables", rises.size() - b_en, 1);
        check("tick_ignored_busy", int'(bus.busy), 0);
        b_d = n_done;
        start_tick(24'h000001);
        @(posedge clk);
        @(negedge clk);
        check("abort_enable_before", int'(bus.enemy_enable), 1);
        #1 reset = 1'b1;
        #1;
        check("abort_enable", int'(bus.enemy_enable), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_x", int'(bus.x_pos), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("abort_no_pass_done", n_done - b_d, 0);
        np = 0;
        observe("abort_origin", 240, 64);
`ifdef ENEMY_FORMATION_PLOT_CNT_EN
        do_reset();
        check("cnt_reset", int'(bus.plotted_cnt), 0);
        run_pass(24'h0000FF, c);
        check("cnt_plotted", int'(bus.plotted_cnt), 8);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
